// File: rtl/psum_ctrl_pkg.sv
// Shared types and constants for the partial-sum SRAM controller.
package psum_ctrl_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACC_WR = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Command opcode carried on i_cmd_op.
    localparam logic OP_CLEAR = 1'b0;
    localparam logic OP_DRAIN = 1'b1;

    // Widest supported word. Users slice WMASK_ALL down to SRAM_W.
    localparam int  WMASK_MAX_W = 1024;
    localparam logic [WMASK_MAX_W-1:0] WMASK_ALL = '1;

endpackage

// File: rtl/psum_range_cnt.sv
// Address pointer / remaining-word counter for CLEAR and DRAIN sweeps.
// The pointer wraps modulo 2^ADR_W; rem counts words still to access.
module psum_range_cnt
    import psum_ctrl_pkg::*;
#(
    parameter int ADR_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [ADR_W-1:0] i_base,
    input  logic [ADR_W:0]   i_len,
    input  logic             i_step,
    output logic [ADR_W-1:0] o_ptr,
    output logic             o_last,
    output logic             o_empty
);

    logic [ADR_W-1:0] r_ptr;
    logic [ADR_W:0]   r_rem;

    // Load a new range, or advance one word per step.
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            r_ptr <= '0;
            r_rem <= '0;
        end else if (i_load) begin
            r_ptr <= i_base;
            r_rem <= i_len;
        end else if (i_step) begin
            r_ptr <= r_ptr + ADR_W'(1);
            r_rem <= r_rem - (ADR_W+1)'(1);
        end
    end

    assign o_ptr   = r_ptr;
    assign o_last  = (r_rem == (ADR_W+1)'(1));
    assign o_empty = (r_rem == '0);

endmodule

// File: rtl/psum_acc_ctrl.sv
// Sole master of the partial-sum SRAM. Accumulates PE-array partial sums
// with read-modify-write, and runs CLEAR / DRAIN sweeps over an address range.
module psum_acc_ctrl
    import psum_ctrl_pkg::*;
#(
    parameter int ADR_W  = 12,
    parameter int SRAM_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_psum_valid,
    output logic              o_psum_ready,
    input  logic [SRAM_W-1:0] i_psum_data,
    input  logic [ADR_W-1:0]  i_psum_addr,
    input  logic              i_psum_first,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_op,
    input  logic [ADR_W-1:0]  i_cmd_base,
    input  logic [ADR_W:0]    i_cmd_len,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [SRAM_W-1:0] o_out_data,
    output logic              o_done,
    output logic              o_busy,
    output logic              o_ram_cen,
    output logic              o_ram_rdwen,
    output logic [ADR_W-1:0]  o_ram_addr,
    output logic [SRAM_W-1:0] o_ram_wdata,
    output logic [SRAM_W-1:0] o_ram_wmask,
    input  logic [SRAM_W-1:0] i_ram_rdata
);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADR_W-1:0]  r_acc_addr;
    logic [SRAM_W-1:0] r_acc_data;
    logic              r_acc_first;
    logic              r_out_valid;

    logic              w_cnt_load;
    logic              w_cnt_step;
    logic [ADR_W-1:0]  w_ptr;
    logic              w_last;
    logic              w_empty;
    logic              w_psum_acc;
    logic              w_drain_rd;
    logic              w_drain_fin;

    psum_range_cnt #(.ADR_W(ADR_W)) u_range_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_cnt_load),
        .i_base  (i_cmd_base),
        .i_len   (i_cmd_len),
        .i_step  (w_cnt_step),
        .o_ptr   (w_ptr),
        .o_last  (w_last),
        .o_empty (w_empty)
    );

    // A command wins over a psum offered in the same IDLE cycle.
    assign w_psum_acc  = (r_state == ST_IDLE) && i_psum_valid && !i_cmd_valid;
    // Issue a drain read only when the output slot is free or being emptied now.
    assign w_drain_rd  = (r_state == ST_DRAIN) && !w_empty && (!r_out_valid || i_out_ready);
    assign w_drain_fin = w_empty && (!r_out_valid || i_out_ready);

    // Next-state decode and SRAM port drive.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_next_state = r_state;
        o_cmd_ready  = 1'b0;
        o_psum_ready = 1'b0;
        o_ram_cen    = 1'b1;
        o_ram_rdwen  = 1'b1;
        o_ram_addr   = '0;
        o_ram_wdata  = '0;
        o_ram_wmask  = '0;
        w_cnt_load   = 1'b0;
        w_cnt_step   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                o_cmd_ready  = 1'b1;
                o_psum_ready = !i_cmd_valid;
                if (i_cmd_valid) begin
                    w_cnt_load = 1'b1;
                    if (i_cmd_len == '0)
                        w_next_state = ST_DONE;
                    else if (i_cmd_op == OP_CLEAR)
                        w_next_state = ST_CLEAR;
                    else
                        w_next_state = ST_DRAIN;
                end else if (i_psum_valid) begin
                    o_ram_cen    = 1'b0;
                    o_ram_addr   = i_psum_addr;
                    w_next_state = ST_ACC_WR;
                end
            end
            ST_ACC_WR: begin
                o_ram_cen    = 1'b0;
                o_ram_rdwen  = 1'b0;
                o_ram_addr   = r_acc_addr;
                o_ram_wmask  = WMASK_ALL[SRAM_W-1:0];
                o_ram_wdata  = r_acc_first ? r_acc_data : (i_ram_rdata + r_acc_data);
                w_next_state = ST_IDLE;
            end
            ST_CLEAR: begin
                o_ram_cen   = 1'b0;
                o_ram_rdwen = 1'b0;
                o_ram_addr  = w_ptr;
                o_ram_wmask = WMASK_ALL[SRAM_W-1:0];
                w_cnt_step  = 1'b1;
                if (w_last)
                    w_next_state = ST_DONE;
            end
            ST_DRAIN: begin
                if (w_drain_rd) begin
                    o_ram_cen  = 1'b0;
                    o_ram_addr = w_ptr;
                    w_cnt_step = 1'b1;
                end
                if (w_drain_fin)
                    w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // Capture the accepted psum for the write cycle that follows its read.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc_addr  <= '0;
            r_acc_data  <= '0;
            r_acc_first <= 1'b0;
        end else if (w_psum_acc) begin
            r_acc_addr  <= i_psum_addr;
            r_acc_data  <= i_psum_data;
            r_acc_first <= i_psum_first;
        end
    end

    // Drain output valid: set one cycle after a read, cleared by a handshake with no new read.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_out_valid <= 1'b0;
        else if (w_drain_rd)
            r_out_valid <= 1'b1;
        else if (i_out_ready)
            r_out_valid <= 1'b0;
    end

    // The SRAM output register holds while cen is high, so it doubles as the output buffer.
    assign o_out_valid = r_out_valid;
    assign o_out_data  = i_ram_rdata;
    assign o_done      = (r_state == ST_DONE);
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Self-checking bench for psum_acc_ctrl: directed corner cases plus random traffic,
// with an SRAM behavioural model and a word-level reference memory.
module tb_psum_acc_ctrl;

    localparam int ADR_W  = 12;
    localparam int SRAM_W = 32;
    localparam int DEPTH  = 1 << ADR_W;

    logic              clk;
    logic              i_rst;
    logic              i_psum_valid;
    logic              o_psum_ready;
    logic [SRAM_W-1:0] i_psum_data;
    logic [ADR_W-1:0]  i_psum_addr;
    logic              i_psum_first;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic              i_cmd_op;
    logic [ADR_W-1:0]  i_cmd_base;
    logic [ADR_W:0]    i_cmd_len;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [SRAM_W-1:0] o_out_data;
    logic              o_done;
    logic              o_busy;
    logic              o_ram_cen;
    logic              o_ram_rdwen;
    logic [ADR_W-1:0]  o_ram_addr;
    logic [SRAM_W-1:0] o_ram_wdata;
    logic [SRAM_W-1:0] o_ram_wmask;
    logic [SRAM_W-1:0] ram_rdata;

    psum_acc_ctrl #(.ADR_W(ADR_W), .SRAM_W(SRAM_W)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_psum_valid (i_psum_valid),
        .o_psum_ready (o_psum_ready),
        .i_psum_data  (i_psum_data),
        .i_psum_addr  (i_psum_addr),
        .i_psum_first (i_psum_first),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_op     (i_cmd_op),
        .i_cmd_base   (i_cmd_base),
        .i_cmd_len    (i_cmd_len),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data   (o_out_data),
        .o_done       (o_done),
        .o_busy       (o_busy),
        .o_ram_cen    (o_ram_cen),
        .o_ram_rdwen  (o_ram_rdwen),
        .o_ram_addr   (o_ram_addr),
        .o_ram_wdata  (o_ram_wdata),
        .o_ram_wmask  (o_ram_wmask),
        .i_ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM model (single port, registered read) ----------------
    logic [SRAM_W-1:0] mem [DEPTH];
    logic              mem_init;

    function automatic logic [SRAM_W-1:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (!o_ram_cen) begin
            if (!o_ram_rdwen)
                mem[o_ram_addr] <= (mem[o_ram_addr] & ~o_ram_wmask) | (o_ram_wdata & o_ram_wmask);
            else
                ram_rdata <= mem[o_ram_addr];
        end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [SRAM_W-1:0] ref_mem [DEPTH];
    logic [SRAM_W-1:0] exp_q [$];
    int                n_vec  = 0;
    int                n_fail = 0;
    int                hs_cnt = 0;
    int                stall_left = 0;
    bit                rnd_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop expected drain words on every handshake; check data holds while stalled.
    initial begin : monitor
        logic              held_valid;
        logic [SRAM_W-1:0] held_data;
        held_valid = 1'b0;
        held_data  = '0;
        forever begin
            @(negedge clk);
            if (held_valid && o_out_valid)
                check("drain_hold", o_out_data, held_data);
            if (o_out_valid && i_out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL drain_extra: got word 0x%0h, expected none", o_out_data);
                end else begin
                    check("drain_word", o_out_data, exp_q.pop_front());
                end
            end
            held_valid = o_out_valid && !i_out_ready;
            held_data  = o_out_data;
        end
    end

    // Downstream ready: scripted 3-cycle stall on word 1, otherwise random or always-ready.
    initial begin : ready_gen
        i_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && o_out_valid && hs_cnt == 1) begin
                i_out_ready = 1'b0;
                stall_left--;
            end else begin
                i_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // One psum: read at accept cycle t, write at t+1, ready again at t+2.
    task automatic do_psum(input int addr, input logic [SRAM_W-1:0] data, input bit first);
        ref_mem[addr] = first ? data : ref_mem[addr] + data;
        @(posedge clk); #1;
        i_psum_valid = 1'b1;
        i_psum_addr  = ADR_W'(addr);
        i_psum_data  = data;
        i_psum_first = first;
        @(negedge clk);
        check("psum_ready_idle", o_psum_ready, 1);
        check("psum_read_issue", {o_ram_cen, o_ram_rdwen, o_ram_addr}, {2'b01, ADR_W'(addr)});
        @(posedge clk); #1;
        i_psum_valid = 1'b0;
        check("psum_ready_wr", o_psum_ready, 0);
        check("psum_write_issue", {o_ram_cen, o_ram_rdwen}, 2'b00);
        @(posedge clk); #1;
        check("psum_mem", mem[addr], ref_mem[addr]);
        check("psum_ready_again", o_psum_ready, 1);
    endtask

    // One command; waits (bounded) for o_done and optionally checks its latency.
    task automatic do_cmd(input logic op, input int base, input int len,
                          input bit chk_lat, input int exp_lat);
        int cyc;
        bit got;
        for (int i = 0; i < len; i++) begin
            if (op == 1'b1) exp_q.push_back(ref_mem[(base + i) % DEPTH]);
            else            ref_mem[(base + i) % DEPTH] = '0;
        end
        hs_cnt = 0;
        @(posedge clk); #1;
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_base  = ADR_W'(base);
        i_cmd_len   = (ADR_W+1)'(len);
        @(negedge clk);
        check("cmd_ready", o_cmd_ready, 1);
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (len == 0) check("len0_no_cen", o_ram_cen, 1);
            if (o_done) got = 1'b1;
        end
        check("cmd_done_seen", got, 1);
        if (chk_lat) check("done_latency", cyc, exp_lat);
        if (op == 1'b1) check("drain_all_delivered", exp_q.size(), 0);
    endtask

    initial begin : stim
        int r;
        i_rst        = 1'b1;
        mem_init     = 1'b1;
        i_psum_valid = 1'b0;
        i_psum_data  = '0;
        i_psum_addr  = '0;
        i_psum_first = 1'b0;
        i_cmd_valid  = 1'b0;
        i_cmd_op     = 1'b0;
        i_cmd_base   = '0;
        i_cmd_len    = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        check("rst_cen_rdwen", {o_ram_cen, o_ram_rdwen}, 2'b11);
        check("rst_busy_done", {o_busy, o_done}, 2'b00);
        check("rst_out_valid", o_out_valid, 0);
        i_rst = 1'b0;

        // Overwrite then accumulate.
        do_psum('h10, 32'd5, 1'b1);
        do_psum('h10, 32'd7, 1'b0);
        check("acc_result", mem['h10], 32'd12);

        // Accumulate wraps modulo 2^32.
        do_psum('h11, 32'hFFFF_FFFF, 1'b1);
        do_psum('h11, 32'd2, 1'b0);
        check("acc_wrap", mem['h11], 32'h0000_0001);

        // CLEAR across the top of the address space.
        do_psum(2, 32'hA5A5_0001, 1'b1);
        do_cmd(1'b0, 4094, 4, 1'b1, 5);
        check("clear_4094", mem[4094], 0);
        check("clear_4095", mem[4095], 0);
        check("clear_0", mem[0], 0);
        check("clear_1", mem[1], 0);
        check("clear_keep_2", mem[2], 32'hA5A5_0001);

        // DRAIN with a 3-cycle stall on word 1.
        rnd_ready  = 1'b0;
        stall_left = 3;
        do_cmd(1'b1, 0, 4, 1'b0, 0);
        check("stall_consumed", stall_left, 0);

        // Command and psum in the same cycle: command wins; len 0 finishes next cycle.
        @(posedge clk); #1;
        i_cmd_valid  = 1'b1;
        i_cmd_op     = 1'b1;
        i_cmd_base   = '0;
        i_cmd_len    = '0;
        i_psum_valid = 1'b1;
        i_psum_addr  = ADR_W'('h20);
        i_psum_data  = 32'h1234;
        i_psum_first = 1'b1;
        @(negedge clk);
        check("prio_psum_ready", o_psum_ready, 0);
        check("prio_cmd_ready", o_cmd_ready, 1);
        check("prio_no_cen", o_ram_cen, 1);
        @(posedge clk); #1;
        i_cmd_valid  = 1'b0;
        i_psum_valid = 1'b0;
        check("len0_done", {o_done, o_busy, o_ram_cen}, 3'b111);
        @(posedge clk); #1;
        check("len0_after", {o_done, o_busy}, 2'b00);
        check("prio_psum_dropped", mem['h20], ref_mem['h20]);

        // Reset in the middle of a DRAIN.
        for (int i = 0; i < 8; i++) exp_q.push_back(ref_mem[8 + i]);
        hs_cnt = 0;
        @(posedge clk); #1;
        i_cmd_valid = 1'b1;
        i_cmd_op    = 1'b1;
        i_cmd_base  = ADR_W'(8);
        i_cmd_len   = (ADR_W+1)'(8);
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_busy", o_busy, 0);
        check("rst_mid_out_valid", o_out_valid, 0);
        check("rst_mid_cen", o_ram_cen, 1);
        i_rst = 1'b0;
        exp_q.delete();

        // Random traffic over a small address window so psums collide.
        rnd_ready = 1'b1;
        repeat (60) begin
            r = $urandom_range(0, 9);
            if (r < 6)
                do_psum($urandom_range(0, 63), $urandom, 1'($urandom_range(0, 1)));
            else if (r < 8)
                do_cmd(1'b0, $urandom_range(0, 63), $urandom_range(0, 8), 1'b0, 0);
            else
                do_cmd(1'b1, $urandom_range(0, 63), $urandom_range(0, 8), 1'b0, 0);
        end

        @(posedge clk); #1;
        for (int a = 0; a < 72; a++) check("final_mem", mem[a], ref_mem[a]);
        check("final_mem_4094", mem[4094], ref_mem[4094]);
        check("final_mem_4095", mem[4095], ref_mem[4095]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
